// File: rtl/old_new_interrupt_ctrl.sv
// old_new_interrupt_ctrl
//   Eight-line interrupt controller. Each HARDWARE line is synchronised and
//   edge-detected. Rising edges latch into PENDING. The block tracks the
//   interrupt in service ("old") and the best waiting one ("new"), and it
//   flags preemption when new outranks old. Line 0 has the highest priority.
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   HARDWARE   [7:0] asynchronous request lines
//   MASK       [7:0] per-line mask (only when INT_MASK_EN is defined)
//   CLR_Input  [3:0] 0-7 clear line n, 8-14 no-op, 15 clear all
//   PENDING    [7:0] latched pending interrupts
//   IRQ        OR of enabled pending bits
//   OLD_VALID / OLD_ID   in-service interrupt
//   NEW_VALID / NEW_ID   best pending interrupt other than the in-service one
//   PREEMPT    new outranks old
//
// Build option: define INT_MASK_EN to add the MASK input.
module old_new_interrupt_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] HARDWARE,
`ifdef INT_MASK_EN
  input  logic [7:0] MASK,
`endif
  input  logic [3:0] CLR_Input,
  output logic [7:0] PENDING,
  output logic       IRQ,
  output logic       OLD_VALID,
  output logic [2:0] OLD_ID,
  output logic       NEW_VALID,
  output logic [2:0] NEW_ID,
  output logic       PREEMPT
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] prev_q;
  logic [7:0] pend_q, pend_d;
  logic       old_valid_q, old_valid_d;
  logic [2:0] old_id_q, old_id_d;

  logic [7:0] mask_w;
  logic [7:0] edge_w;
  logic [7:0] clr_w;
  logic [7:0] elig_w;
  logic [7:0] new_cand_w;
  logic [7:0] old_oh_w;

`ifdef INT_MASK_EN
  assign mask_w = MASK;
`else
  assign mask_w = 8'h00;
`endif

  // Lowest set index wins.
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q      <= '0;
      prev_q      <= 8'h00;
      pend_q      <= 8'h00;
      old_valid_q <= 1'b0;
      old_id_q    <= 3'd0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], HARDWARE};
      prev_q      <= sync_q[SYNC_STAGES-1];
      pend_q      <= pend_d;
      old_valid_q <= old_valid_d;
      old_id_q    <= old_id_d;
    end
  end

  always_comb begin
    edge_w = sync_q[SYNC_STAGES-1] & ~prev_q & ~mask_w;

    clr_w = 8'h00;
    if (CLR_Input == 4'd15) begin
      clr_w = 8'hFF;
    end else if (!CLR_Input[3]) begin
      clr_w = 8'h01 << CLR_Input[2:0];
    end

    // A set in the same cycle overrides the clear.
    pend_d = (pend_q & ~clr_w) | edge_w;

    elig_w = pend_q & ~mask_w;

    old_valid_d = old_valid_q;
    old_id_d    = old_id_q;
    if (old_valid_q) begin
      if (!pend_d[old_id_q]) begin
        old_valid_d = 1'b0;
        old_id_d    = 3'd0;
      end
    end else if (|elig_w) begin
      old_valid_d = 1'b1;
      old_id_d    = prio_enc(elig_w);
    end

    old_oh_w   = old_valid_q ? (8'h01 << old_id_q) : 8'h00;
    new_cand_w = elig_w & ~old_oh_w;
  end

  assign PENDING   = pend_q;
  assign IRQ       = |elig_w;
  assign OLD_VALID = old_valid_q;
  assign OLD_ID    = old_id_q;
  assign NEW_VALID = |new_cand_w;
  assign NEW_ID    = (|new_cand_w) ? prio_enc(new_cand_w) : 3'd0;
  assign PREEMPT   = NEW_VALID & old_valid_q & (NEW_ID < old_id_q);

endmodule

// File: tb/tb_old_new_interrupt_ctrl.sv
module tb_old_new_interrupt_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] HARDWARE = 8'h00;
  logic [3:0] CLR_Input = 4'd8;
`ifdef INT_MASK_EN
  logic [7:0] MASK = 8'h00;
`endif
  logic [7:0] PENDING;
  logic       IRQ, OLD_VALID, NEW_VALID, PREEMPT;
  logic [2:0] OLD_ID, NEW_ID;

  int vectors = 0;
  int miscompares = 0;

  // {PENDING, IRQ, OLD_VALID, OLD_ID, NEW_VALID, NEW_ID, PREEMPT}
  logic [17:0] obs;
  assign obs = {PENDING, IRQ, OLD_VALID, OLD_ID, NEW_VALID, NEW_ID, PREEMPT};

  always #5 CLK = ~CLK;

  old_new_interrupt_ctrl #(.SYNC_STAGES(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .HARDWARE  (HARDWARE),
`ifdef INT_MASK_EN
    .MASK      (MASK),
`endif
    .CLR_Input (CLR_Input),
    .PENDING   (PENDING),
    .IRQ       (IRQ),
    .OLD_VALID (OLD_VALID),
    .OLD_ID    (OLD_ID),
    .NEW_VALID (NEW_VALID),
    .NEW_ID    (NEW_ID),
    .PREEMPT   (PREEMPT)
  );

  function automatic logic [17:0] pack(input logic [7:0] p, input logic irq, input logic ov,
                                       input logic [2:0] oid, input logic nv,
                                       input logic [2:0] nid, input logic pre);
    return {p, irq, ov, oid, nv, nid, pre};
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    HARDWARE = 8'h00;
    CLR_Input = 4'd8;
    tick(2);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] exp;
    RST = 1'b1;
    HARDWARE = 8'h00;
    CLR_Input = 4'd8;
    tick(2);
    exp = '0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_during obs=%h exp=%h", obs, exp);
    end
    // Keep the reset asserted; the release follows with new inputs.
    HARDWARE = 8'h7F;
    CLR_Input = 4'd2;
    tick(1);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_inputs_ignored obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_release_edges();
    logic [17:0] exp;
    RST = 1'b0;
    tick(2);
    exp = '0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL release_2edges obs=%h exp=%h", obs, exp);
    end
    tick(1);
    exp = pack(8'h7F, 1, 0, 3'd0, 1, 3'd0, 0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL release_3edges obs=%h exp=%h", obs, exp);
    end
    tick(1);
    exp = pack(8'h7B, 1, 1, 3'd0, 1, 3'd1, 0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL release_clr2_load0 obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_clear_old();
    logic [17:0] exp;
    CLR_Input = 4'd0;
    tick(1);
    exp = pack(8'h7A, 1, 0, 3'd0, 1, 3'd1, 0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL clear_old_drop obs=%h exp=%h", obs, exp);
    end
    CLR_Input = 4'd8;
    tick(1);
    exp = pack(8'h7A, 1, 1, 3'd1, 1, 3'd3, 0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL clear_old_reload obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_preempt();
    logic [17:0] exp;
    do_reset();
    HARDWARE = 8'h20;
    tick(3);
    exp = pack(8'h20, 1, 0, 3'd0, 1, 3'd5, 0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL preempt_pend5 obs=%h exp=%h", obs, exp);
    end
    tick(1);
    exp = pack(8'h20, 1, 1, 3'd5, 0, 3'd0, 0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL preempt_old5 obs=%h exp=%h", obs, exp);
    end
    HARDWARE = 8'h22;
    tick(2);
    exp = pack(8'h20, 1, 1, 3'd5, 0, 3'd0, 0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL preempt_latency obs=%h exp=%h", obs, exp);
    end
    tick(1);
    exp = pack(8'h22, 1, 1, 3'd5, 1, 3'd1, 1);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL preempt_flag obs=%h exp=%h", obs, exp);
    end
    HARDWARE = 8'h20;
    tick(3);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL preempt_old_sticky obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_level_held();
    do_reset();
    HARDWARE = 8'h10;
    CLR_Input = 4'd4;
    tick(3);
    vectors++;
    if (PENDING[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL level_set_wins got=%b exp=1", PENDING[4]);
    end
    tick(1);
    vectors++;
    if (PENDING !== 8'h00) begin
      miscompares++;
      $display("FAIL level_cleared got=%h exp=00", PENDING);
    end
    CLR_Input = 4'd8;
    tick(4);
    vectors++;
    if (PENDING !== 8'h00) begin
      miscompares++;
      $display("FAIL level_no_reset got=%h exp=00", PENDING);
    end
    HARDWARE = 8'h00;
    tick(3);
    HARDWARE = 8'h10;
    tick(3);
    vectors++;
    if (PENDING !== 8'h10) begin
      miscompares++;
      $display("FAIL level_reraise got=%h exp=10", PENDING);
    end
  endtask

  task automatic test_clear_all();
    logic [17:0] exp;
    do_reset();
    HARDWARE = 8'h0C;
    tick(4);
    CLR_Input = 4'd12;
    tick(1);
    exp = pack(8'h0C, 1, 1, 3'd2, 1, 3'd3, 0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL clear_noop obs=%h exp=%h", obs, exp);
    end
    CLR_Input = 4'd15;
    tick(1);
    exp = '0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL clear_all obs=%h exp=%h", obs, exp);
    end
    CLR_Input = 4'd8;
  endtask

  task automatic test_async_reset();
    logic [17:0] exp;
    do_reset();
    HARDWARE = 8'hFF;
    tick(3);
    vectors++;
    if (PENDING !== 8'hFF) begin
      miscompares++;
      $display("FAIL async_pre got=%h exp=ff", PENDING);
    end
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    exp = '0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL async_immediate obs=%h exp=%h", obs, exp);
    end
    HARDWARE = 8'h00;
    tick(1);
    RST = 1'b0;
    tick(3);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL async_after obs=%h exp=%h", obs, exp);
    end
  endtask

`ifdef INT_MASK_EN
  task automatic test_mask();
    do_reset();
    MASK = 8'hFF;
    HARDWARE = 8'hFF;
    tick(5);
    vectors++;
    if (PENDING !== 8'h00 || IRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL mask_all got=%h/%b exp=00/0", PENDING, IRQ);
    end
    MASK = 8'h00;
    HARDWARE = 8'h00;
  endtask
`endif

  initial begin
    test_reset();
    test_release_edges();
    test_clear_old();
    test_preempt();
    test_level_held();
    test_clear_all();
    test_async_reset();
`ifdef INT_MASK_EN
    test_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/old_new_interrupt_ctrl.md
Name: old_new_interrupt_ctrl

Overview:
- 8-line hardware interrupt controller with a 4-bit clear command port.
- Synchronises the HARDWARE request lines and latches rising edges into a pending register.
- Tracks the interrupt currently in service ("old") and the highest-priority waiting interrupt ("new").
- Flags preemption when the new interrupt outranks the old one; sits between peripheral request lines and the processor's interrupt/exception logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per HARDWARE line (min 2).

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- HARDWARE  input  8  asynchronous interrupt request lines; bit n = line n.
- CLR_Input  input  4  clear command: 0-7 clear line n; 8-14 no-op; 15 clear all.
- PENDING  output  8  latched pending interrupts.
- IRQ  output  1  OR of PENDING.
- OLD_VALID  output  1  an interrupt is in service.
- OLD_ID  output  3  index of the in-service interrupt; 0 when OLD_VALID=0.
- NEW_VALID  output  1  a pending interrupt other than OLD_ID exists.
- NEW_ID  output  3  highest-priority pending index, excluding OLD_ID while OLD_VALID=1; 0 when NEW_VALID=0.
- PREEMPT  output  1  NEW_VALID & OLD_VALID & (NEW_ID < OLD_ID).

Behaviour:
- Reset (async, RST=1) clears all synchroniser flops, the edge-history register, PENDING, OLD_VALID and OLD_ID; all outputs read 0.
- Because sync flops reset to 0, any line already high at reset release counts as a rising edge.
- Each line passes through SYNC_STAGES flops, then is compared with its registered previous value; edge = sync & ~prev.
- PENDING[n] is set on the clock after an edge is detected. With SYNC_STAGES=2, a HARDWARE 0->1 change is visible on PENDING after the 3rd rising CLK edge.
- Level held high does not re-set PENDING after it is cleared; a new 0->1 transition is required.
- Clear: CLR_Input=n (0-7) clears PENDING[n] on each edge while held; 15 clears all bits; 8-14 have no effect. CLR_Input is sampled synchronously and not synchronised.
- Set and clear of the same bit in the same cycle: the set wins. The bit stays pending and a held clear removes it the following cycle.
- Priority: lower index = higher priority; line 0 is highest.
- OLD state:
  - When OLD_VALID=0 and PENDING≠0, the next edge loads OLD_ID = highest-priority pending index and sets OLD_VALID=1.
  - OLD_VALID drops on the edge where the clear command removes PENDING[OLD_ID] (n=OLD_ID or 15). A new OLD may load on the following edge.
  - OLD_ID does not change while OLD_VALID=1, even if PREEMPT is asserted; the processor must clear it.
- NEW_ID, NEW_VALID, PREEMPT and IRQ are combinational from the registered PENDING/OLD state; no latency beyond PENDING.
- RST asserted mid-operation discards all pending and in-service state immediately.

Optional Feature:
- Macro INT_MASK_EN.
- Defined: adds input MASK[7:0]. MASK[n]=1 blocks edge n from setting PENDING[n]. Already-pending bits stay pending but are excluded from IRQ, NEW_ID and OLD loading while masked.
- Undefined: no MASK port; all lines enabled.

Test Plan:
- Reset with HARDWARE=0, CLR_Input=8 -> all outputs 0 during and after reset.
- Release reset with HARDWARE=127, CLR_Input=2 -> PENDING=0x7F after 3 edges, then 0x7B next edge; OLD_ID=0, OLD_VALID=1; NEW_ID=1; IRQ=1; PREEMPT=0.
- From previous state, CLR_Input=0 for one cycle then 8 -> PENDING=0x7A, OLD_VALID=0, then OLD_ID=1 loaded next edge; NEW_ID=3.
- OLD_ID=5 in service, then pulse HARDWARE[1] 0->1 -> PENDING[1] set after 3 edges; NEW_ID=1, PREEMPT=1; OLD_ID stays 5.
- HARDWARE[4] held high, CLR_Input=4 continuously -> PENDING[4] sets once then clears; no re-set while the level is held. Drop and re-raise the line -> pending again.
- RST pulsed asynchronously mid-cycle with PENDING=0xFF -> outputs 0 immediately, without waiting for CLK. With INT_MASK_EN and MASK=0xFF, edges on all lines -> PENDING stays 0.
